// File: rtl/bram_mover_pkg.sv
// +--------------------------------------------------------------------------+
// | bram_mover_pkg : shared constants and FSM state type for bram_mover      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package bram_mover_pkg;

  localparam int WORD_BYTES  = 4;
  localparam int BRAM_RD_LAT = 2;
  localparam int LEN_W       = 14;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    CAP  = 3'd3,
    WR   = 3'd4,
    FIN  = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bram_mover_if.sv
// +--------------------------------------------------------------------------+
// | bram_mover_if : 32-bit byte-addressed BRAM port (initiator/target views) |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface bram_mover_if #(
  parameter int ADDR_W = 15
) ();

  logic [ADDR_W-1:0] BRAM_ADDR;
  logic [31:0]       BRAM_WRDATA;
  logic [31:0]       BRAM_RDDATA;
  logic              BRAM_EN;
  logic [3:0]        BRAM_WE;

  modport master (
    output BRAM_ADDR,
    output BRAM_WRDATA,
    output BRAM_EN,
    output BRAM_WE,
    input  BRAM_RDDATA
  );

  modport slave (
    input  BRAM_ADDR,
    input  BRAM_WRDATA,
    input  BRAM_EN,
    input  BRAM_WE,
    output BRAM_RDDATA
  );

endinterface

`default_nettype wire

// File: rtl/bram_mover.sv
// +--------------------------------------------------------------------------+
// | bram_mover : reads LEN words from SRC, adds ADD_VAL, writes them to DST. |
// | Optional chksum output enabled by macro BRAM_MOVER_CHKSUM_EN.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module bram_mover
  import bram_mover_pkg::*;
#(
  parameter int          BRAM_ADDR_WIDTH = 15,
  parameter logic [31:0] ADD_VAL         = 32'd1
) (
  input  wire logic                       BRAM_CLK,
  input  wire logic                       BRAM_RST,
  input  wire logic                       start,
  input  wire logic [BRAM_ADDR_WIDTH-1:0] src_base,
  input  wire logic [BRAM_ADDR_WIDTH-1:0] dst_base,
  input  wire logic [LEN_W-1:0]           len,
  output logic                            busy,
  output logic                            done,
  bram_mover_if.master                    bram
`ifdef BRAM_MOVER_CHKSUM_EN
  ,output logic [31:0]                    chksum
`endif
);

  localparam logic [BRAM_ADDR_WIDTH-1:0] STEP  = BRAM_ADDR_WIDTH'(WORD_BYTES);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ALIGN = ~BRAM_ADDR_WIDTH'(WORD_BYTES - 1);

  state_e                     state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0] src_q, src_d;
  logic [BRAM_ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]           cnt_q, cnt_d;
  logic [31:0]                data_q, data_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       armed_q;
  logic [31:0]                chk_q, chk_d;

  logic [BRAM_ADDR_WIDTH-1:0] bram_addr;
  logic [31:0]                bram_wrdata;
  logic                       bram_en;
  logic [3:0]                 bram_we;

  // armed_q stays low for the first edge after reset release, so a start
  // coinciding with deassertion is never accepted.
  always_ff @(posedge BRAM_CLK or posedge BRAM_RST) begin
    if (BRAM_RST) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
      chk_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      armed_q <= 1'b1;
      chk_q   <= chk_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    chk_d       = chk_q;
    bram_addr   = '0;
    bram_wrdata = '0;
    bram_en     = 1'b0;
    bram_we     = 4'h0;

    case (state_q)
      IDLE: begin
        if (start && armed_q) begin
          src_d   = src_base & ALIGN;
          dst_d   = dst_base & ALIGN;
          cnt_d   = len;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          chk_d   = '0;
          state_d = (len == '0) ? FIN : RD;
        end
      end
      RD: begin
        bram_addr = src_q;
        bram_en   = 1'b1;
        state_d   = WAIT;
      end
      // Address held a second cycle to honour the two-cycle read latency.
      WAIT: begin
        bram_addr = src_q;
        bram_en   = 1'b1;
        state_d   = CAP;
      end
      CAP: begin
        data_d  = bram.BRAM_RDDATA + ADD_VAL;
        chk_d   = chk_q + bram.BRAM_RDDATA;
        state_d = WR;
      end
      WR: begin
        bram_addr   = dst_q;
        bram_en     = 1'b1;
        bram_we     = 4'hF;
        bram_wrdata = data_q;
        src_d       = src_q + STEP;
        dst_d       = dst_q + STEP;
        cnt_d       = cnt_q - 1'b1;
        state_d     = (cnt_q == LEN_W'(1)) ? FIN : RD;
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bram.BRAM_ADDR   = bram_addr;
  assign bram.BRAM_WRDATA = bram_wrdata;
  assign bram.BRAM_EN     = bram_en;
  assign bram.BRAM_WE     = bram_we;
  assign busy             = busy_q;
  assign done             = done_q;

`ifdef BRAM_MOVER_CHKSUM_EN
  assign chksum = chk_q;
`else
  logic chk_unused;
  assign chk_unused = ^chk_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bram_mover.sv
// +--------------------------------------------------------------------------+
// | tb_bram_mover : directed, table-driven bench for bram_mover with a       |
// | two-cycle-latency BRAM model. Rev 1.0                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_bram_mover;

  localparam int AW    = 15;
  localparam int DEPTH = 8192;

  typedef struct {
    logic [AW-1:0]     src;
    logic [AW-1:0]     dst;
    logic [13:0]       len;
    logic [3:0][31:0]  din;
    logic [3:0][31:0]  exp;
    int                lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic [13:0]   len = '0;
  logic          busy;
  logic          done;
`ifdef BRAM_MOVER_CHKSUM_EN
  logic [31:0]   chksum;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_mover_if #(.ADDR_W(AW)) bus ();

  bram_mover #(.BRAM_ADDR_WIDTH(AW), .ADD_VAL(32'd1)) dut (
    .BRAM_CLK (clk),
    .BRAM_RST (rst),
    .start    (start),
    .src_base (src_base),
    .dst_base (dst_base),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .bram     (bus)
`ifdef BRAM_MOVER_CHKSUM_EN
    ,.chksum  (chksum)
`endif
  );

  // BRAM model: registered address stage plus registered data stage.
  logic [31:0] mem [DEPTH];
  logic [31:0] rd1_q;
  logic        pl_we = 1'b0;
  logic [12:0] pl_idx = '0;
  logic [31:0] pl_data = '0;
  int          en_cycles = 0;

  always @(posedge clk) begin
    if (pl_we)
      mem[pl_idx] <= pl_data;
    else if (bus.BRAM_EN && bus.BRAM_WE == 4'hF)
      mem[bus.BRAM_ADDR[AW-1:2]] <= bus.BRAM_WRDATA;
    rd1_q           <= mem[bus.BRAM_ADDR[AW-1:2]];
    bus.BRAM_RDDATA <= rd1_q;
    if (bus.BRAM_EN) en_cycles <= en_cycles + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] d);
    @(negedge clk);
    pl_we   = 1'b1;
    pl_idx  = 13'(idx % DEPTH);
    pl_data = d;
    @(negedge clk);
    pl_we   = 1'b0;
  endtask

  function automatic int widx(input logic [AW-1:0] base, input int i);
    return (int'(base[AW-1:2]) + i) % DEPTH;
  endfunction

  // Launches a transfer; inj>0 pulses a competing start lat==inj cycles in.
  task automatic run_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [13:0] n, input int inj,
                          output int lat, output bit ok);
    @(negedge clk);
    src_base = s;
    dst_base = d;
    len      = n;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ok    = busy && !done;
    lat   = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == inj) begin
        start    = 1'b1;
        src_base = 15'h0200;
        dst_base = 15'h0A00;
        len      = 14'd1;
      end else begin
        start = 1'b0;
      end
      if (done) break;
      if (!busy) ok = 1'b0;
    end
    start = 1'b0;
  endtask

  function automatic vec_t mk(input logic [AW-1:0] s, input logic [AW-1:0] d,
                              input logic [13:0] n,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3,
                              input int l);
    vec_t v;
    v.src = s; v.dst = d; v.len = n;
    v.din = {a3, a2, a1, a0};
    v.exp = {e3, e2, e1, e0};
    v.lat = l;
    return v;
  endfunction

  vec_t vecs [6];

  initial begin
    int  lat;
    bit  ok;
    int  en0;

    vecs[0] = mk(15'h0000, 15'h0100, 14'd4, 32'h10, 32'h20, 32'h30, 32'hFFFFFFFF,
                 32'h11, 32'h21, 32'h31, 32'h0, 17);
    vecs[1] = mk(15'h0200, 15'h0300, 14'd1, 32'h5, 0, 0, 0, 32'h6, 0, 0, 0, 5);
    vecs[2] = mk(15'h0403, 15'h0502, 14'd2, 32'h7FFFFFFF, 32'hA, 0, 0,
                 32'h80000000, 32'hB, 0, 0, 9);
    vecs[3] = mk(15'h0600, 15'h0604, 14'd3, 32'h1, 32'h9, 32'h9, 0,
                 32'h2, 32'h3, 32'h4, 0, 13);
    vecs[4] = mk(15'h7FFC, 15'h0000, 14'd2, 32'h100, 32'h200, 0, 0,
                 32'h101, 32'h102, 0, 0, 9);
    vecs[5] = mk(15'h0800, 15'h0900, 14'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_bus", {bus.BRAM_ADDR, bus.BRAM_EN, bus.BRAM_WE}, 32'h0);
    chk("reset_wrdata", bus.BRAM_WRDATA, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < int'(vecs[v].len); i++) poke(widx(vecs[v].dst, i), 32'hDEADBEEF);
      for (int i = 0; i < int'(vecs[v].len); i++) poke(widx(vecs[v].src, i), vecs[v].din[i]);
      en0 = en_cycles;
      run_xfer(vecs[v].src, vecs[v].dst, vecs[v].len, 0, lat, ok);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
      chk($sformatf("v%0d_busy_window", v), 32'(ok), 32'h1);
      chk($sformatf("v%0d_busy_end", v), 32'(busy), 32'h0);
      chk($sformatf("v%0d_en_cycles", v), 32'(en_cycles - en0), 32'(3 * int'(vecs[v].len)));
      for (int i = 0; i < int'(vecs[v].len); i++)
        chk($sformatf("v%0d_dst%0d", v, i), mem[widx(vecs[v].dst, i)], vecs[v].exp[i]);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_done_held", v), 32'(done), 32'h1);
    end

    // Competing start mid-transfer must be ignored.
    for (int i = 0; i < 4; i++) poke(64 + i, 32'h0);
    poke(0, 32'h10); poke(1, 32'h20); poke(2, 32'h30); poke(3, 32'hFFFFFFFF);
    poke(640, 32'h0);
    run_xfer(15'h0000, 15'h0100, 14'd4, 5, lat, ok);
    chk("mid_start_latency", 32'(lat), 32'd17);
    chk("mid_start_busy", 32'(ok), 32'h1);
    chk("mid_start_dst0", mem[64], 32'h11);
    chk("mid_start_dst3", mem[67], 32'h0);
    chk("mid_start_other_dst", mem[640], 32'h0);

    // Asynchronous reset after two words of an eight-word transfer.
    for (int i = 0; i < 8; i++) poke(2048 + i, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) poke(1024 + i, 32'h51 + 32'(i));
    @(negedge clk);
    src_base = 15'h1000; dst_base = 15'h2000; len = 14'd8; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy_done", {30'h0, busy, done}, 32'h0);
    chk("abort_bus", {bus.BRAM_ADDR, bus.BRAM_EN, bus.BRAM_WE}, 32'h0);
    chk("abort_wrdata", bus.BRAM_WRDATA, 32'h0);
    repeat (3) @(posedge clk);
    chk("abort_dst0", mem[2048], 32'h52);
    chk("abort_dst1", mem[2049], 32'h53);
    chk("abort_dst2", mem[2050], 32'hDEADBEEF);
    chk("abort_dst7", mem[2055], 32'hDEADBEEF);

    // Start on the first edge after reset release is not accepted.
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_at_release", 32'(busy), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("start_at_release_idle", {30'h0, busy, bus.BRAM_EN}, 32'h0);

    run_xfer(15'h1000, 15'h2000, 14'd8, 0, lat, ok);
    chk("rerun_latency", 32'(lat), 32'd33);
    chk("rerun_dst2", mem[2050], 32'h54);
    chk("rerun_dst7", mem[2055], 32'h59);

`ifdef BRAM_MOVER_CHKSUM_EN
    poke(3072, 32'd1); poke(3073, 32'd2); poke(3074, 32'd3);
    run_xfer(15'h3000, 15'h3800, 14'd3, 0, lat, ok);
    chk("chksum", chksum, 32'd6);
    repeat (3) @(negedge clk);
    chk("chksum_stable", chksum, 32'd6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
